fdetect: RTL and testbench
==========================

Name: fdetect

Overview:
- Frequency/period detector: the receive-side counterpart of the on-chip clock dividers.
- Takes a slow, asynchronous square wave (for example a divided clock returned from another board region or device).
- Measures its period and high time in F10M cycles.
- Flags lock when the period matches the expected division ratio, and flags a sticky error when the signal stops toggling.

Parameters:
- CNT_W, 16, width of the period/high-time counters and outputs.
- EXPECT, 40, expected period in F10M cycles (divide-by-40 source).
- TOL, 1, allowed |period - EXPECT| deviation, in cycles, for a match.
- LOCK_N, 4, consecutive matching periods required to assert LOCK.
- TIMEOUT, 1000, cycles without a rising edge before TIMEOUT_ERR. Must be < 2^CNT_W - 1.

Ports:
- F10M  input  1  system clock, 10 MHz.
- RESET  input  1  asynchronous, active-low reset.
- SIG_IN  input  1  asynchronous square wave to measure.
- CLR  input  1  synchronous clear of lock/error state, active-high.
- PERIOD  output  CNT_W  last measured rising-to-rising period, in F10M cycles.
- HIGH_T  output  CNT_W  synchronized-high cycles within that period.
- VALID  output  1  one-cycle pulse when PERIOD/HIGH_T update.
- LOCK  output  1  period within tolerance for LOCK_N consecutive measurements.
- TIMEOUT_ERR  output  1  sticky: no rising edge for TIMEOUT cycles.

Behaviour:
- Reset: RESET low asynchronously clears all state.
  - Outputs: PERIOD=0, HIGH_T=0, VALID=0, LOCK=0, TIMEOUT_ERR=0.
  - Synchronizer flops = 0, FSM = WAIT_EDGE, counters = 0.
  - Reset release is synchronous to F10M; first active edge follows. Reset mid-measurement discards the partial period.
- Input path: SIG_IN passes a 2-flop synchronizer (s1, s2) plus a history flop s3.
  - rise = s2 & ~s3.
  - Fixed detection latency: 3 F10M edges after SIG_IN rises (setup met).
- Counting: cnt and hcnt are CNT_W-bit saturating counters (hold at all-ones).
- FSM state WAIT_EDGE: waits for the first rise.
  - On rise: cnt<=1, hcnt<=1, go to MEASURE. No VALID is issued.
  - cnt does not run in this state; no timeout is generated here.
- FSM state MEASURE, each cycle:
  - If rise: PERIOD<=cnt, HIGH_T<=hcnt, VALID=1 on the next cycle (registered, one cycle wide), then cnt<=1, hcnt<=1.
  - Else if cnt==TIMEOUT: TIMEOUT_ERR<=1, LOCK<=0, match count<=0, go to WAIT_EDGE.
  - Else: cnt<=cnt+1; hcnt<=hcnt+1 when s2==1.
  - A rise on the same cycle cnt==TIMEOUT counts as a normal measurement, not a timeout.
- Lock logic: evaluated on each rise in MEASURE, using cnt.
  - Match when EXPECT-TOL <= cnt <= EXPECT+TOL. Compare with unsigned arithmetic; clamp the lower bound at 0.
  - On match: mcnt<=mcnt+1 (saturate at LOCK_N).
  - LOCK rises in the same cycle VALID asserts for the LOCK_N-th consecutive match.
  - On mismatch: mcnt<=0, and LOCK drops with that VALID.
- TIMEOUT_ERR stays set until CLR or RESET. Measurement resumes normally after a timeout, even while TIMEOUT_ERR=1.
- CLR (synchronous, highest priority after RESET):
  - Clears LOCK, mcnt, TIMEOUT_ERR, VALID; FSM returns to WAIT_EDGE.
  - PERIOD/HIGH_T hold.
  - A rise coincident with CLR is ignored.
- Glitches shorter than one F10M period may be missed. This is accepted; no filtering.

Test Plan:
- Reset, then SIG_IN period 40 / high 20 cycles, 6 periods -> no VALID on first rise; VALID every 40 cycles with PERIOD=40, HIGH_T=20; LOCK=1 with the 4th VALID (5th rise).
- Locked, then one period of 41 followed by one of 42 -> 41 keeps LOCK=1; 42 gives PERIOD=42 and LOCK=0 with that VALID; LOCK reasserts after 4 further 40-cycle periods.
- Locked, then SIG_IN held low -> TIMEOUT_ERR=1 and LOCK=0 exactly 1000 cycles after the last cnt=1 cycle; a restarted wave gives VALID again from the 2nd rise while TIMEOUT_ERR stays 1 until CLR pulse.
- Rise arriving on the cycle cnt==1000 -> VALID with PERIOD=1000, TIMEOUT_ERR stays 0; rise one cycle later -> timeout, no VALID.
- RESET pulsed low mid-period and mid-lock -> all outputs 0 immediately (asynchronous); the next measurement needs a fresh first rise.
- CLR asserted on the same cycle as a rise while locked -> LOCK=0, no VALID, PERIOD unchanged; the next two rises yield one VALID.

Source files
------------

// File: rtl/fdetect_if.sv
// Measurement bundle for fdetect: the square wave under test and clear
// going in, period/high-time results and status flags coming out.
// master = the detector (drives results), slave = the consumer/stimulus side.
//
// Ports (signals):
//   SIG_IN       asynchronous square wave to measure
//   CLR          synchronous clear of lock/error state, active-high
//   PERIOD       last rising-to-rising period, in F10M cycles
//   HIGH_T       synchronized-high cycles within that period
//   VALID        one-cycle pulse when PERIOD/HIGH_T update
//   LOCK         period within tolerance for LOCK_N consecutive measurements
//   TIMEOUT_ERR  sticky: no rising edge for TIMEOUT cycles
interface fdetect_if #(
  parameter int unsigned CNT_W = 16
);
  logic             SIG_IN;
  logic             CLR;
  logic [CNT_W-1:0] PERIOD;
  logic [CNT_W-1:0] HIGH_T;
  logic             VALID;
  logic             LOCK;
  logic             TIMEOUT_ERR;

  modport master (
    input  SIG_IN, CLR,
    output PERIOD, HIGH_T, VALID, LOCK, TIMEOUT_ERR
  );

  modport slave (
    output SIG_IN, CLR,
    input  PERIOD, HIGH_T, VALID, LOCK, TIMEOUT_ERR
  );
endinterface

// File: rtl/fdetect.sv
// Period/high-time detector for a slow asynchronous square wave, with lock and sticky timeout flags.
// Latency: rise acted on 3 F10M edges after SIG_IN rises; VALID/LOCK registered one cycle after that.
// Backpressure: none; VALID is a one-cycle pulse the consumer must take when it appears.
//
// Ports:
//   F10M   system clock (10 MHz)
//   RESET  asynchronous active-low reset
//   io     fdetect_if.master: SIG_IN, CLR in; PERIOD, HIGH_T, VALID, LOCK, TIMEOUT_ERR out
//   CNT_W in this module must equal the CNT_W of the connected interface.
module fdetect #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned EXPECT  = 40,
  parameter int unsigned TOL     = 1,
  parameter int unsigned LOCK_N  = 4,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic       F10M,
  input  logic       RESET,
  fdetect_if.master  io
);

  // Tolerance window; lower bound clamps at zero instead of wrapping.
  // Counters are compared zero-extended to 32 bits, so CNT_W is expected <= 32.
  localparam int unsigned LO   = (EXPECT > TOL) ? (EXPECT - TOL) : 0;
  localparam int unsigned HI   = EXPECT + TOL;
  localparam int unsigned MC_W = $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [MC_W-1:0]  MC_MAX  = MC_W'(LOCK_N);

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } state_t;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, hcnt_q;
  logic [CNT_W-1:0] period_q, high_q;
  logic             valid_q, lock_q, terr_q;
  logic [MC_W-1:0]  mcnt_q;

  logic             rise;
  logic             match_d;
  logic [CNT_W-1:0] cnt_d, hcnt_d;
  logic [MC_W-1:0]  mcnt_d;

  assign rise = s2_q & ~s3_q;

  // Saturating increments: counters park at all-ones instead of wrapping.
  assign cnt_d  = (cnt_q  == CNT_MAX) ? cnt_q  : cnt_q  + CNT_W'(1);
  assign hcnt_d = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + CNT_W'(1);

  assign match_d = (32'(cnt_q) >= LO) && (32'(cnt_q) <= HI);

  // Match run length, saturating at LOCK_N; any mismatch restarts the run.
  assign mcnt_d = !match_d            ? '0 :
                  (mcnt_q == MC_MAX)  ? mcnt_q :
                                        mcnt_q + MC_W'(1);

  always_ff @(posedge F10M or negedge RESET) begin
    if (!RESET) begin
      state_q  <= WAIT_EDGE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      lock_q   <= 1'b0;
      terr_q   <= 1'b0;
      mcnt_q   <= '0;
    end else begin
      // Synchronizer keeps shifting under CLR so a coincident rise is consumed, not deferred.
      s1_q    <= io.SIG_IN;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      valid_q <= 1'b0;

      if (io.CLR) begin
        lock_q  <= 1'b0;
        mcnt_q  <= '0;
        terr_q  <= 1'b0;
        state_q <= WAIT_EDGE;
      end else begin
        case (state_q)
          WAIT_EDGE: begin
            // First rise only opens a measurement window; no result yet.
            if (rise) begin
              cnt_q   <= CNT_W'(1);
              hcnt_q  <= CNT_W'(1);
              state_q <= MEASURE;
            end
          end

          MEASURE: begin
            // Rise wins over timeout when both land on the same cycle.
            if (rise) begin
              period_q <= cnt_q;
              high_q   <= hcnt_q;
              valid_q  <= 1'b1;
              cnt_q    <= CNT_W'(1);
              hcnt_q   <= CNT_W'(1);
              mcnt_q   <= mcnt_d;
              lock_q   <= (mcnt_d == MC_MAX);
            end else if (cnt_q == TMO) begin
              terr_q  <= 1'b1;
              lock_q  <= 1'b0;
              mcnt_q  <= '0;
              state_q <= WAIT_EDGE;
            end else begin
              cnt_q <= cnt_d;
              if (s2_q) begin
                hcnt_q <= hcnt_d;
              end
            end
          end

          default: state_q <= WAIT_EDGE;
        endcase
      end
    end
  end

  assign io.PERIOD      = period_q;
  assign io.HIGH_T      = high_q;
  assign io.VALID       = valid_q;
  assign io.LOCK        = lock_q;
  assign io.TIMEOUT_ERR = terr_q;

endmodule

// File: tb/tb_fdetect.sv
// Bench for fdetect: directed SIG_IN waveforms driven on the falling edge;
// each rise that closes a period pushes its hand-computed result, and a
// separate monitor pops and compares whenever VALID is seen.
module tb_fdetect;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fdetect_if #(.CNT_W(16)) io ();

  fdetect #(
    .CNT_W  (16),
    .EXPECT (40),
    .TOL    (1),
    .LOCK_N (4),
    .TIMEOUT(1000)
  ) u_dut (
    .F10M (clk),
    .RESET(rst_n),
    .io   (io)
  );

  typedef struct packed {
    logic [15:0] p;
    logic [15:0] h;
    logic        l;
    logic        t;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // One SIG_IN period starting with a rise at the current falling edge.
  // ev: this rise closes the previous period, whose result (ep, eh, el, et) is expected.
  // clr_at: offset (in cycles from the rise) where CLR is driven for one cycle, -1 for none.
  task automatic pulse(input int len, input int hi, input bit ev, input int ep, input int eh,
                       input bit el, input bit et, input int clr_at);
    if (ev) sb.push_back('{p: 16'(ep), h: 16'(eh), l: el, t: et});
    for (int k = 0; k < len; k++) begin
      io.SIG_IN = (k < hi);
      io.CLR    = (k == clr_at);
      @(negedge clk);
    end
    io.CLR = 1'b0;
  endtask

  // Monitor: every VALID pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (io.VALID === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got PERIOD=%0d HIGH_T=%0d expected no VALID", io.PERIOD, io.HIGH_T);
        end else begin
          e = sb.pop_front();
          chk("period",      io.PERIOD,      e.p);
          chk("high_t",      io.HIGH_T,      e.h);
          chk("lock_at_vld", io.LOCK,        e.l);
          chk("terr_at_vld", io.TIMEOUT_ERR, e.t);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    io.SIG_IN = 1'b0;
    io.CLR    = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period", io.PERIOD,      0);
    chk("rst_high_t", io.HIGH_T,      0);
    chk("rst_valid",  io.VALID,       0);
    chk("rst_lock",   io.LOCK,        0);
    chk("rst_terr",   io.TIMEOUT_ERR, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 40/20 wave: first rise silent, lock with the 4th result.
    pulse(40, 20, 0,  0,  0, 0, 0, -1);
    pulse(40, 20, 1, 40, 20, 0, 0, -1);
    pulse(40, 20, 1, 40, 20, 0, 0, -1);
    pulse(40, 20, 1, 40, 20, 0, 0, -1);
    pulse(40, 20, 1, 40, 20, 1, 0, -1);
    pulse(40, 20, 1, 40, 20, 1, 0, -1);
    chk("lock_after_6", io.LOCK, 1);

    // 41 stays in tolerance, 42 breaks lock; four more 40s relock.
    pulse(41, 20, 1, 40, 20, 1, 0, -1);
    pulse(42, 20, 1, 41, 20, 1, 0, -1);
    pulse(40, 20, 1, 42, 20, 0, 0, -1);
    pulse(40, 20, 1, 40, 20, 0, 0, -1);
    pulse(40, 20, 1, 40, 20, 0, 0, -1);
    pulse(40, 20, 1, 40, 20, 0, 0, -1);

    // Last rise (relock result), then SIG_IN stays low: timeout 1000 cycles after cnt=1.
    sb.push_back('{p: 16'd40, h: 16'd20, l: 1'b1, t: 1'b0});
    for (int k = 0; k < 1010; k++) begin
      if (k == 1002) begin
        chk("terr_before_tmo", io.TIMEOUT_ERR, 0);
        chk("lock_before_tmo", io.LOCK,        1);
      end
      if (k == 1003) begin
        chk("terr_at_tmo", io.TIMEOUT_ERR, 1);
        chk("lock_at_tmo", io.LOCK,        0);
      end
      io.SIG_IN = (k < 20);
      @(negedge clk);
    end

    // Restart while TIMEOUT_ERR is set; CLR during the third period clears it.
    pulse(40, 20, 0,  0,  0, 0, 0, -1);
    pulse(40, 20, 1, 40, 20, 0, 1, -1);
    chk("terr_sticky", io.TIMEOUT_ERR, 1);
    pulse(40, 20, 1, 40, 20, 0, 1, 30);
    chk("terr_after_clr", io.TIMEOUT_ERR, 0);
    chk("lock_after_clr", io.LOCK,        0);

    // Rise exactly at cnt==1000 measures; one cycle later times out instead.
    pulse(1000, 20, 0,    0,  0, 0, 0, -1);
    pulse(1001, 20, 1, 1000, 20, 0, 0, -1);
    pulse(40,   20, 0,    0,  0, 0, 0, -1);
    chk("terr_after_1001", io.TIMEOUT_ERR, 1);
    pulse(40, 20, 1, 40, 20, 0, 1, -1);
    pulse(40, 20, 1, 40, 20, 0, 1, -1);
    pulse(40, 20, 1, 40, 20, 0, 1, -1);
    pulse(40, 20, 1, 40, 20, 1, 1, -1);
    pulse(40, 20, 1, 40, 20, 1, 1, -1);
    chk("lock_before_rst", io.LOCK, 1);

    // Asynchronous reset mid-period while locked.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_period", io.PERIOD,      0);
    chk("arst_high_t", io.HIGH_T,      0);
    chk("arst_valid",  io.VALID,       0);
    chk("arst_lock",   io.LOCK,        0);
    chk("arst_terr",   io.TIMEOUT_ERR, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh first rise needed, then relock.
    pulse(40, 20, 0,  0,  0, 0, 0, -1);
    pulse(40, 20, 1, 40, 20, 0, 0, -1);
    pulse(40, 20, 1, 40, 20, 0, 0, -1);
    pulse(40, 20, 1, 40, 20, 0, 0, -1);
    pulse(40, 20, 1, 40, 20, 1, 0, -1);

    // CLR lands on the rise cycle: rise ignored, no VALID, PERIOD holds.
    pulse(40, 20, 0, 0, 0, 0, 0, 2);
    chk("lock_clr_rise",   io.LOCK,   0);
    chk("period_clr_rise", io.PERIOD, 40);
    pulse(40, 20, 0,  0,  0, 0, 0, -1);
    pulse(40, 20, 1, 40, 20, 0, 0, -1);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
